// File: rtl/spi_flash_arbiter.sv
// Two-master SPI flash arbiter: one owner per chip-select window, guard gap between owners.
// Optional hold timeout with forced revoke is enabled by defining SPI_FLASH_ARB_TIMEOUT_EN.
module spi_flash_arbiter #(
    parameter int GUARD_CYCLES   = 4,
    parameter int TIMEOUT_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       dsp_enable,
    input  logic       cpu_enable,
    input  logic       dsp_spi_clk,
    input  logic       dsp_spi_mosi,
    input  logic       dsp_spi_cs_INV,
    output logic       dsp_spi_miso,
    input  logic       cpu_spi_clk,
    input  logic       cpu_spi_mosi,
    input  logic       cpu_spi_cs_INV,
    output logic       cpu_spi_miso,
    output logic       flash_clk,
    output logic       flash_mosi,
    output logic       flash_cs_INV,
    input  logic       flash_miso,
    output logic [1:0] grant,
    output logic       busy,
    output logic [7:0] collision_count,
    output logic       timeout_flag
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] GRANT_DSP = 2'd1;
    localparam logic [1:0] GRANT_CPU = 2'd2;
    localparam logic [1:0] GUARD     = 2'd3;

    logic [1:0] state, state_next;
    logic [7:0] guard_cnt;
    logic       last_owner;     // 1 = CPU
    logic [1:0] dsp_cs_sync, cpu_cs_sync;
    logic       dsp_req, cpu_req, dsp_req_q, cpu_req_q;
    logic       dsp_elig, cpu_elig, timeout_hit;
    logic       dsp_denied, cpu_denied;
    logic [8:0] coll_sum;

    if (GUARD_CYCLES < 1 || GUARD_CYCLES > 255) begin : g_bad_guard
        $error("GUARD_CYCLES out of range");
    end
    if (TIMEOUT_CYCLES < 1 || longint'(TIMEOUT_CYCLES) >= (longint'(1) << TIMEOUT_WIDTH)) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES does not fit TIMEOUT_WIDTH");
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            dsp_cs_sync <= '1;
            cpu_cs_sync <= '1;
        end else begin
            dsp_cs_sync <= {dsp_cs_sync[0], dsp_spi_cs_INV};
            cpu_cs_sync <= {cpu_cs_sync[0], cpu_spi_cs_INV};
        end
    end

    assign dsp_req = dsp_enable & ~dsp_cs_sync[1];
    assign cpu_req = cpu_enable & ~cpu_cs_sync[1];

`ifdef SPI_FLASH_ARB_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] hold_cnt;
    logic                     dsp_lock, cpu_lock, timeout_q;

    assign dsp_elig    = dsp_req & ~dsp_lock;
    assign cpu_elig    = cpu_req & ~cpu_lock;
    assign timeout_hit = ((state == GRANT_DSP && dsp_req) || (state == GRANT_CPU && cpu_req)) &&
                         (hold_cnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));
    assign timeout_flag = timeout_q;

    // A revoked owner stays locked out until its request drops, so a stuck CS cannot re-grant.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            hold_cnt  <= '0;
            dsp_lock  <= 1'b0;
            cpu_lock  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            hold_cnt  <= ((state == GRANT_DSP || state == GRANT_CPU) && state_next == state) ?
                         hold_cnt + 1'b1 : '0;
            if (!dsp_req)                              dsp_lock <= 1'b0;
            else if (timeout_hit && state == GRANT_DSP) dsp_lock <= 1'b1;
            if (!cpu_req)                              cpu_lock <= 1'b0;
            else if (timeout_hit && state == GRANT_CPU) cpu_lock <= 1'b1;
            timeout_q <= timeout_q | timeout_hit;
        end
    end
`else
    assign dsp_elig     = dsp_req;
    assign cpu_elig     = cpu_req;
    assign timeout_hit  = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (dsp_elig && cpu_elig) state_next = last_owner ? GRANT_DSP : GRANT_CPU;
                else if (dsp_elig)        state_next = GRANT_DSP;
                else if (cpu_elig)        state_next = GRANT_CPU;
            end
            GRANT_DSP: if (!dsp_req || timeout_hit) state_next = GUARD;
            GRANT_CPU: if (!cpu_req || timeout_hit) state_next = GUARD;
            GUARD:     if (guard_cnt == 8'(GUARD_CYCLES - 1)) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // A request edge is a collision when the next cycle does not grant it.
    assign dsp_denied = dsp_req & ~dsp_req_q & (state_next != GRANT_DSP);
    assign cpu_denied = cpu_req & ~cpu_req_q & (state_next != GRANT_CPU);
    assign coll_sum   = {1'b0, collision_count} + 9'(dsp_denied) + 9'(cpu_denied);

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            guard_cnt       <= '0;
            last_owner      <= 1'b1;
            dsp_req_q       <= 1'b0;
            cpu_req_q       <= 1'b0;
            collision_count <= '0;
        end else begin
            state     <= state_next;
            guard_cnt <= (state == GUARD && state_next == GUARD) ? guard_cnt + 8'd1 : '0;
            if (state == GRANT_DSP && state_next == GUARD) last_owner <= 1'b0;
            if (state == GRANT_CPU && state_next == GUARD) last_owner <= 1'b1;
            dsp_req_q       <= dsp_req;
            cpu_req_q       <= cpu_req;
            collision_count <= (coll_sum > 9'd255) ? 8'hFF : coll_sum[7:0];
        end
    end

    always_comb begin
        grant        = 2'b00;
        flash_cs_INV = 1'b1;
        flash_clk    = 1'b0;
        flash_mosi   = 1'b0;
        dsp_spi_miso = 1'b1;
        cpu_spi_miso = 1'b1;
        case (state)
            GRANT_DSP: begin
                grant        = 2'b01;
                flash_cs_INV = dsp_spi_cs_INV | ~dsp_enable;
                flash_clk    = dsp_spi_clk;
                flash_mosi   = dsp_spi_mosi;
                dsp_spi_miso = flash_miso;
            end
            GRANT_CPU: begin
                grant        = 2'b10;
                flash_cs_INV = cpu_spi_cs_INV | ~cpu_enable;
                flash_clk    = cpu_spi_clk;
                flash_mosi   = cpu_spi_mosi;
                cpu_spi_miso = flash_miso;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Scoreboard bench for spi_flash_arbiter: reference model predicts status changes, monitor compares.
module tb_spi_flash_arbiter;
    localparam int G = 4;
`ifdef SPI_FLASH_ARB_TIMEOUT_EN
    localparam int TC = 100;
    localparam bit TO = 1'b1;
`else
    localparam int TC = 65535;
    localparam bit TO = 1'b0;
`endif

    logic sysclk = 1'b0;
    logic reset = 1'b1;
    logic dsp_enable, cpu_enable;
    logic dsp_spi_clk, dsp_spi_mosi, dsp_spi_cs_INV, dsp_spi_miso;
    logic cpu_spi_clk, cpu_spi_mosi, cpu_spi_cs_INV, cpu_spi_miso;
    logic flash_clk, flash_mosi, flash_cs_INV, flash_miso;
    logic [1:0] grant;
    logic busy, timeout_flag;
    logic [7:0] collision_count;

    int checks = 0;
    int errors = 0;

    spi_flash_arbiter #(.GUARD_CYCLES(G), .TIMEOUT_WIDTH(16), .TIMEOUT_CYCLES(TC)) dut (
        .sysclk(sysclk), .reset(reset),
        .dsp_enable(dsp_enable), .cpu_enable(cpu_enable),
        .dsp_spi_clk(dsp_spi_clk), .dsp_spi_mosi(dsp_spi_mosi),
        .dsp_spi_cs_INV(dsp_spi_cs_INV), .dsp_spi_miso(dsp_spi_miso),
        .cpu_spi_clk(cpu_spi_clk), .cpu_spi_mosi(cpu_spi_mosi),
        .cpu_spi_cs_INV(cpu_spi_cs_INV), .cpu_spi_miso(cpu_spi_miso),
        .flash_clk(flash_clk), .flash_mosi(flash_mosi),
        .flash_cs_INV(flash_cs_INV), .flash_miso(flash_miso),
        .grant(grant), .busy(busy),
        .collision_count(collision_count), .timeout_flag(timeout_flag)
    );

    always #5 sysclk = ~sysclk;

    // Reference model: owner (-1 none, 0 DSP, 1 CPU), guard cycles left, round-robin memory.
    int   m_owner, m_guard, m_last, m_coll, m_tcnt;
    bit   m_tflag;
    bit   m_s1[2], m_s2[2], m_prev[2], m_lock[2];
    logic [11:0] m_tup = '0;
    logic [11:0] exp_q[$];
    bit   mon_on = 1'b0;

    function automatic logic [11:0] model_tuple();
        logic [1:0] g;
        g = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
        return {g, (m_owner >= 0 || m_guard > 0), 8'(m_coll), m_tflag};
    endfunction

    task automatic publish();
        logic [11:0] t;
        t = model_tuple();
        if (t !== m_tup) begin
            exp_q.push_back(t);
            m_tup = t;
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_guard = 0; m_last = 1; m_coll = 0; m_tcnt = 0; m_tflag = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_s1[i] = 1'b1; m_s2[i] = 1'b1; m_prev[i] = 1'b0; m_lock[i] = 1'b0;
        end
        publish();
    endtask

    task automatic model_step();
        bit en[2], cs[2], req[2], rise[2], elig[2];
        int nxt, to_now;
        en[0] = dsp_enable;     en[1] = cpu_enable;
        cs[0] = dsp_spi_cs_INV; cs[1] = cpu_spi_cs_INV;
        for (int i = 0; i < 2; i++) begin
            req[i]  = en[i] && !m_s2[i];
            rise[i] = req[i] && !m_prev[i];
            elig[i] = req[i] && !(TO && m_lock[i]);
        end
        nxt = m_owner;
        to_now = -1;
        if (m_owner >= 0) begin
            if (!req[m_owner]) nxt = -1;
            else if (TO && m_tcnt == TC - 1) begin
                nxt = -1;
                to_now = m_owner;
            end
            if (nxt < 0) begin
                m_guard = G; m_last = m_owner; m_tcnt = 0;
            end else m_tcnt++;
        end else if (m_guard > 0) m_guard--;
        else if (elig[0] && elig[1]) nxt = (m_last == 1) ? 0 : 1;
        else if (elig[0]) nxt = 0;
        else if (elig[1]) nxt = 1;
        for (int i = 0; i < 2; i++) begin
            if (rise[i] && nxt != i && m_coll < 255) m_coll++;
            if (!req[i]) m_lock[i] = 1'b0;
            else if (to_now == i) m_lock[i] = 1'b1;
            m_s2[i] = m_s1[i]; m_s1[i] = cs[i]; m_prev[i] = req[i];
        end
        if (to_now >= 0) m_tflag = 1'b1;
        m_owner = nxt;
        publish();
    endtask

    always @(posedge sysclk) if (!reset) model_step();

    // Monitor: every status change the DUT presents is matched against the next predicted one.
    logic [11:0] mon_prev = '0;
    always @(negedge sysclk) begin : monitor
        logic [11:0] d, e;
        logic [4:0]  pa, pe;
        if (mon_on) begin
            d = {grant, busy, collision_count, timeout_flag};
            if (d !== mon_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected t=%0t got %h with no expected change", $time, d);
                end else begin
                    e = exp_q.pop_front();
                    if (d !== e) begin
                        errors++;
                        $display("FAIL sb_status t=%0t got %h expected %h", $time, d, e);
                    end
                end
                mon_prev = d;
            end
            if (m_owner == 0)
                pe = {dsp_spi_cs_INV | ~dsp_enable, dsp_spi_clk, dsp_spi_mosi, flash_miso, 1'b1};
            else if (m_owner == 1)
                pe = {cpu_spi_cs_INV | ~cpu_enable, cpu_spi_clk, cpu_spi_mosi, 1'b1, flash_miso};
            else
                pe = 5'b10011;
            pa = {flash_cs_INV, flash_clk, flash_mosi, dsp_spi_miso, cpu_spi_miso};
            checks++;
            if (pa !== pe) begin
                errors++;
                $display("FAIL pins t=%0t got %b expected %b", $time, pa, pe);
            end
        end
    end

    task automatic cyc();
        @(posedge sysclk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic wait_grant(input logic [1:0] g, input int maxc, input string name);
        int n = 0;
        while (grant !== g && n < maxc) begin
            cyc();
            n++;
        end
        chk(name, 32'(grant), 32'(g));
    endtask

    initial begin
        logic [7:0] tx, rx, got_mosi, got_miso;
        int n;
        tx = 8'h9F;
        rx = 8'hEF;
        dsp_enable = 1'b1; cpu_enable = 1'b1;
        dsp_spi_cs_INV = 1'b1; cpu_spi_cs_INV = 1'b1;
        dsp_spi_clk = 1'b0; dsp_spi_mosi = 1'b0;
        cpu_spi_clk = 1'b0; cpu_spi_mosi = 1'b0;
        flash_miso = 1'b1;
        model_reset();
        cyc();
        mon_on = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        chk("reset_state", 32'({grant, busy, collision_count, timeout_flag, flash_cs_INV,
                                flash_clk, flash_mosi, dsp_spi_miso, cpu_spi_miso}),
            32'({12'h000, 5'b10011}));

        // First tie after reset goes to the DSP; the CPU edge is a collision.
        dsp_spi_cs_INV = 1'b0; cpu_spi_cs_INV = 1'b0;
        wait_grant(2'b01, 4, "tie1_grant");
        cyc();
        chk("tie1_coll", 32'(collision_count), 32'd1);
        for (int b = 7; b >= 0; b--) begin
            dsp_spi_mosi = tx[b];
            flash_miso   = rx[b];
            dsp_spi_clk  = 1'b0;
            cyc();
            dsp_spi_clk  = 1'b1;
            #1;
            got_mosi[b] = flash_mosi;
            got_miso[b] = dsp_spi_miso;
            cyc();
        end
        dsp_spi_clk = 1'b0;
        chk("byte_mosi", 32'(got_mosi), 32'h9F);
        chk("byte_miso", 32'(got_miso), 32'hEF);
        dsp_spi_cs_INV = 1'b1; cpu_spi_cs_INV = 1'b1;
        wait_grant(2'b00, 6, "dsp_release");
        n = 0;
        while (busy && n < 20) begin
            cyc();
            n++;
        end
        chk("guard_len", 32'(n), 32'(G));

        // last_owner is now DSP, so the CPU wins the next tie.
        dsp_spi_cs_INV = 1'b0; cpu_spi_cs_INV = 1'b0;
        wait_grant(2'b10, 4, "tie2_grant");
        cyc();
        chk("tie2_coll", 32'(collision_count), 32'd2);
        dsp_spi_cs_INV = 1'b1;
        repeat (4) cyc();
        for (int k = 0; k < 300; k++) begin
            dsp_spi_cs_INV = 1'b0;
            repeat (3) cyc();
            dsp_spi_cs_INV = 1'b1;
            repeat (3) cyc();
        end
        chk("coll_saturate", 32'(collision_count), 32'd255);
        chk("cpu_kept", 32'(grant), 32'b10);

        // Enable drop while DSP owns the flash.
        cpu_spi_cs_INV = 1'b1;
        repeat (10) cyc();
        dsp_spi_cs_INV = 1'b0;
        wait_grant(2'b01, 4, "dsp_grant");
        dsp_spi_clk = 1'b1; cyc();
        dsp_spi_clk = 1'b0; cyc();
        dsp_enable = 1'b0;
        #1;
        chk("en_drop_cs", 32'(flash_cs_INV), 32'd1);
        wait_grant(2'b00, 2, "en_drop_revoke");
        repeat (2) cyc();
        dsp_enable = 1'b1;
        wait_grant(2'b01, 10, "reenable_grant");

        // Reset mid-transfer with the CPU granted and SCK active.
        dsp_spi_cs_INV = 1'b1;
        repeat (10) cyc();
        cpu_spi_cs_INV = 1'b0;
        wait_grant(2'b10, 4, "cpu_grant");
        repeat (5) begin
            cpu_spi_clk = ~cpu_spi_clk;
            cyc();
        end
        cpu_spi_clk = 1'b1;
        reset = 1'b1;
        model_reset();
        #1;
        chk("reset_async", 32'({grant, flash_cs_INV, flash_clk, collision_count}),
            32'({2'b00, 1'b1, 1'b0, 8'h00}));
        repeat (2) cyc();
        reset = 1'b0;
        cpu_spi_clk = 1'b0;
        wait_grant(2'b10, 4, "post_reset_grant");

`ifdef SPI_FLASH_ARB_TIMEOUT_EN
        n = 0;
        while (grant !== 2'b00 && n < TC + 10) begin
            cyc();
            n++;
        end
        chk("timeout_at", 32'(n), 32'(TC));
        chk("timeout_flag", 32'(timeout_flag), 32'd1);
        repeat (50) cyc();
        chk("no_regrant", 32'(grant), 32'b00);
        dsp_spi_cs_INV = 1'b0;
        wait_grant(2'b01, 6, "dsp_after_timeout");
`else
        repeat (10000) cyc();
        chk("long_hold", 32'(grant), 32'b10);
        chk("no_timeout", 32'(timeout_flag), 32'd0);
`endif
        dsp_spi_cs_INV = 1'b1; cpu_spi_cs_INV = 1'b1;
        repeat (10) cyc();

        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 19) == 0) dsp_spi_cs_INV = ~dsp_spi_cs_INV;
            if ($urandom_range(0, 19) == 0) cpu_spi_cs_INV = ~cpu_spi_cs_INV;
            if (dsp_enable ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 19) == 0))
                dsp_enable = ~dsp_enable;
            if (cpu_enable ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 19) == 0))
                cpu_enable = ~cpu_enable;
            dsp_spi_clk  = 1'($urandom);
            dsp_spi_mosi = 1'($urandom);
            cpu_spi_clk  = 1'($urandom);
            cpu_spi_mosi = 1'($urandom);
            flash_miso   = 1'($urandom);
            cyc();
        end
        dsp_spi_cs_INV = 1'b1; cpu_spi_cs_INV = 1'b1;
        dsp_enable = 1'b1; cpu_enable = 1'b1;
        repeat (20) cyc();
        chk("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
